// File: rtl/wb_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_if
// Bundle of the register-file write-side signals around wb_port_arbiter.
//   primary   : p_we, p_rd, p_d          (datapath writeback, never stalled)
//   secondary : s_valid, s_ready, s_rd, s_d (multi-cycle producer, valid/ready)
//   write port: we, rd, d                (to the register file)
//   status    : pending (per-register buffered-write flags), count (occupancy)
// modport master : producer/datapath side (drives requests, sees status)
// modport slave  : arbiter side
// ---------------------------------------------------------------------------
interface wb_port_arbiter_if #(
  parameter int SECT  = 5,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              p_we;
  logic [SECT-1:0]   p_rd;
  logic [31:0]       p_d;
  logic              s_valid;
  logic              s_ready;
  logic [SECT-1:0]   s_rd;
  logic [31:0]       s_d;
  logic              we;
  logic [SECT-1:0]   rd;
  logic [31:0]       d;
  logic [2**SECT-1:0] pending;
  logic [CW-1:0]     count;

  modport master (
    output p_we, p_rd, p_d, s_valid, s_rd, s_d,
    input  s_ready, we, rd, d, pending, count
  );

  modport slave (
    input  p_we, p_rd, p_d, s_valid, s_rd, s_d,
    output s_ready, we, rd, d, pending, count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
// Merges the single-cycle datapath writeback (primary) with buffered results
// of a multi-cycle producer (secondary) onto one register-file write port.
// Secondary results wait in a DEPTH-entry FIFO and drain into idle slots.
// Ports:
//   clk   : rising-edge clock shared with the register file
//   rst_n : synchronous active-low reset
//   bus   : wb_port_arbiter_if.slave (request, write-port and status signals)
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int SECT  = 5,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_port_arbiter_if.slave   bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 2 ** SECT;

  // FIFO storage: live flags need a global clear (kill), so they are flops;
  // rd/d are plain arrays written only at the tail.
  logic [DEPTH-1:0] live_reg, live_next;
  logic [SECT-1:0]  rd_mem [DEPTH];
  logic [31:0]      d_mem  [DEPTH];
  logic [PW-1:0]    head_reg, tail_reg;
  logic [CW-1:0]    count_reg;

  logic             p_act;
  logic             fifo_empty;
  logic             head_live;
  logic             pop;
  logic             push;
  logic             push_live;
  logic             ready_int;
  logic [DEPTH-1:0] kill_hit;
  logic [NREG-1:0]  pending_vec;

  // A primary write only takes the port when out of reset and not aimed at r0.
  assign p_act      = rst_n && bus.p_we && (bus.p_rd != '0);
  assign fifo_empty = (count_reg == '0);
  assign head_live  = live_reg[head_reg];
  // Any idle slot pops the head: live heads are written, killed heads dropped.
  assign pop        = rst_n && !p_act && !fifo_empty;
  assign ready_int  = rst_n && (count_reg != CW'(DEPTH));
  assign push       = bus.s_valid && ready_int;
  // Results for r0, or already superseded by a same-cycle primary write,
  // are stored dead so they only occupy a slot.
  assign push_live  = (bus.s_rd != '0) && !(p_act && (bus.p_rd == bus.s_rd));

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
      assign kill_hit[gi] = p_act && (rd_mem[gi] == bus.p_rd);
    end
  endgenerate

  // Kill first, then clear the popped slot, then install the new tail entry.
  // Tail and head never coincide while popping and pushing together, since a
  // push needs a non-full FIFO and head==tail with entries means full.
  always_comb begin
    live_next = live_reg & ~kill_hit;
    if (pop) begin
      live_next[head_reg] = 1'b0;
    end
    if (push) begin
      live_next[tail_reg] = push_live;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live_reg  <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      live_reg  <= live_next;
      if (push) begin
        tail_reg <= tail_reg + 1'b1;
      end
      if (pop) begin
        head_reg <= head_reg + 1'b1;
      end
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // Payload storage; push is already blocked during reset via ready_int.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_reg] <= bus.s_rd;
      d_mem[tail_reg]  <= bus.s_d;
    end
  end

  // Popped/empty slots always have live cleared, so scanning every slot is
  // equivalent to scanning only the occupied ones. r0 is never stored live.
  always_comb begin
    pending_vec = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (live_reg[i] && (rd_mem[i] == SECT'(r))) begin
          pending_vec[r] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.we = 1'b0;
    bus.rd = '0;
    bus.d  = '0;
    if (p_act) begin
      bus.we = 1'b1;
      bus.rd = bus.p_rd;
      bus.d  = bus.p_d;
    end else if (pop && head_live) begin
      bus.we = 1'b1;
      bus.rd = rd_mem[head_reg];
      bus.d  = d_mem[head_reg];
    end
  end

  // Status reads as cleared for the whole reset cycle, matching the state
  // the FIFO will hold after the reset edge.
  assign bus.s_ready = ready_int;
  assign bus.pending = rst_n ? pending_vec : '0;
  assign bus.count   = rst_n ? count_reg : '0;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
// Scoreboard bench: the stimulus task runs a queue-based model of the write
// port and pushes expected status and expected writes; a monitor process
// pops and compares them against the DUT once per cycle.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;
  localparam int SECT  = 5;
  localparam int DEPTH = 4;

  typedef struct packed {
    bit        live;
    bit [4:0]  rd;
    bit [31:0] d;
  } ent_t;

  typedef struct packed {
    int        cyc;
    int        count;
    bit [31:0] pending;
    bit        ready;
  } st_t;

  typedef struct packed {
    int        cyc;
    bit [4:0]  rd;
    bit [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  wb_port_arbiter_if #(.SECT(SECT), .DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(.SECT(SECT), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ent_t mq[$];      // model FIFO contents, oldest first
  st_t  st_q[$];    // expected status, one per cycle
  wr_t  wr_q[$];    // expected register-file writes
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   last_acc = 0;

  // Model: expectations come from the state before the edge, then the state
  // advances by the edge's rules.
  task automatic model_step(input bit rst, input bit pwe, input bit [4:0] prd,
                            input bit [31:0] pd, input bit sv,
                            input bit [4:0] srd, input bit [31:0] sd);
    st_t s;
    wr_t w;
    ent_t e;
    bit pact;
    s.cyc = cyc;
    s.count = rst ? mq.size() : 0;
    s.pending = '0;
    if (rst) begin
      foreach (mq[i]) if (mq[i].live) s.pending[mq[i].rd] = 1'b1;
    end
    s.ready = rst && (mq.size() < DEPTH);
    st_q.push_back(s);
    pact = rst && pwe && (prd != 0);
    if (pact) begin
      w.cyc = cyc; w.rd = prd; w.d = pd;
      wr_q.push_back(w);
    end else if (rst && mq.size() > 0 && mq[0].live) begin
      w.cyc = cyc; w.rd = mq[0].rd; w.d = mq[0].d;
      wr_q.push_back(w);
    end
    last_acc = sv && s.ready;
    if (!rst) begin
      mq.delete();
    end else begin
      if (!pact && mq.size() > 0) void'(mq.pop_front());
      if (pact) begin
        foreach (mq[i]) if (mq[i].rd == prd) mq[i].live = 1'b0;
      end
      if (last_acc) begin
        e.live = (srd != 0) && !(pact && prd == srd);
        e.rd = srd; e.d = sd;
        mq.push_back(e);
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit pwe, input bit [4:0] prd,
                       input bit [31:0] pd, input bit sv,
                       input bit [4:0] srd, input bit [31:0] sd);
    @(negedge clk);
    rst_n = rst;
    bus.p_we = pwe; bus.p_rd = prd; bus.p_d = pd;
    bus.s_valid = sv; bus.s_rd = srd; bus.s_d = sd;
    #1;
    model_step(rst, pwe, prd, pd, sv, srd, sd);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: samples mid-cycle, after the stimulus has settled.
  always @(negedge clk) begin
    st_t s;
    wr_t w;
    #3;
    if (st_q.size() > 0) begin
      s = st_q.pop_front();
      checks++;
      if (int'(bus.count) != s.count) begin
        errors++;
        $display("FAIL count cyc=%0d got=%0d exp=%0d", s.cyc, bus.count, s.count);
      end
      checks++;
      if (bus.pending != s.pending) begin
        errors++;
        $display("FAIL pending cyc=%0d got=%h exp=%h", s.cyc, bus.pending, s.pending);
      end
      checks++;
      if (bus.s_ready != s.ready) begin
        errors++;
        $display("FAIL s_ready cyc=%0d got=%0b exp=%0b", s.cyc, bus.s_ready, s.ready);
      end
      checks++;
      if (bus.we) begin
        if (wr_q.size() == 0 || wr_q[0].cyc != s.cyc) begin
          errors++;
          $display("FAIL unexpected_write cyc=%0d got rd=%0d d=%h exp no write",
                   s.cyc, bus.rd, bus.d);
        end else begin
          w = wr_q.pop_front();
          if (bus.rd != w.rd || bus.d != w.d) begin
            errors++;
            $display("FAIL write cyc=%0d got rd=%0d d=%h exp rd=%0d d=%h",
                     s.cyc, bus.rd, bus.d, w.rd, w.d);
          end else begin
            $display("cyc=%0d write rd=%0d d=%h ok", s.cyc, bus.rd, bus.d);
          end
        end
      end else begin
        if (wr_q.size() > 0 && wr_q[0].cyc == s.cyc) begin
          w = wr_q.pop_front();
          errors++;
          $display("FAIL missing_write cyc=%0d got we=0 exp rd=%0d d=%h",
                   s.cyc, w.rd, w.d);
        end else if (bus.rd != '0 || bus.d != '0) begin
          errors++;
          $display("FAIL idle_zero cyc=%0d got rd=%0d d=%h exp 0", s.cyc, bus.rd, bus.d);
        end
      end
    end
  end

  initial begin
    bit sv = 0;
    bit [4:0] srd = 0;
    bit [31:0] sd = 0;
    bit rst, pwe;
    bit [4:0] prd;
    bit [31:0] pd;
    int hi;

    bus.p_we = 0; bus.p_rd = 0; bus.p_d = 0;
    bus.s_valid = 0; bus.s_rd = 0; bus.s_d = 0;

    // Reset, then one secondary result drained into an idle slot.
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 6, 32'h66, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 7, 32'hDEAD_BEEF);
    idle(2);

    // Continuous primary writes fill the FIFO, then it drains in order.
    for (int k = 0; k < 6; k++)
      cycle(1, 1, 3, 32'h300 + k, k < 4, 5'(8 + k), 32'h100 + k);
    idle(5);

    // Buffered r5 superseded by a primary write in its drain cycle.
    cycle(1, 0, 0, 0, 1, 5, 32'h5555);
    cycle(1, 1, 5, 32'h1, 0, 0, 0);
    idle(3);

    // Same-cycle push and primary write to r9.
    cycle(1, 1, 9, 32'h99, 1, 9, 32'hBAD);
    idle(3);

    // Primary write to r0 leaves the slot to the head; s_rd=0 stored dead.
    cycle(1, 0, 0, 0, 1, 4, 32'h44);
    cycle(1, 1, 0, 32'hF0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 32'h77);
    idle(3);

    // Fill to three entries, then reset drops them.
    for (int k = 0; k < 3; k++)
      cycle(1, 1, 3, 32'h30, 1, 5'(12 + k), 32'hC0 + k);
    cycle(0, 1, 3, 32'h31, 0, 0, 0);
    idle(4);

    // Randomized traffic with bursty primary load and occasional resets.
    for (int n = 0; n < 800; n++) begin
      if (!(sv && !last_acc)) begin
        sv  = ($urandom_range(0, 2) != 0);
        srd = 5'($urandom_range(0, 15));
        sd  = $urandom;
      end
      hi  = ((n / 40) % 2 == 0) ? 85 : 25;
      rst = ($urandom_range(0, 99) != 0);
      pwe = ($urandom_range(0, 99) < hi);
      prd = 5'($urandom_range(0, 15));
      pd  = $urandom;
      cycle(rst, pwe, prd, pd, sv, srd, sd);
    end
    idle(6);

    repeat (2) @(negedge clk);
    #5;
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_writes got=%0d exp=0", wr_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
